// File: rtl/cordic_arbiter_pkg.sv
// rtl/cordic_arbiter_pkg.sv - shared constants and tag-width helper for the CORDIC arbiter
package cordic_arbiter_pkg;

    localparam int DEFAULT_IO_WIDTH        = 26;
    localparam int DEFAULT_MAX_OUTSTANDING = 32;

    // Never returns zero, so a two-requester tag is still one real bit wide.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/cordic_arbiter_rr_select.sv
// rtl/cordic_arbiter_rr_select.sv - round-robin pick of one eligible requester after the last grant
module rr_select
    import cordic_arbiter_pkg::*;
#(
    parameter int  NREQ = 4,
    localparam int TW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] eligible_i,
    input  logic [TW-1:0]   last_grant_i,
    output logic [NREQ-1:0] grant_o,
    output logic [TW-1:0]   grant_idx_o,
    output logic            grant_valid_o
);

    logic [TW-1:0] cand;

    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        cand          = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = TW'((int'(last_grant_i) + i) % NREQ);
            if (!grant_valid_o && eligible_i[cand]) begin
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - shares one CORDIC among NREQ requesters with credit limits and a result watchdog
module cordic_arbiter
    import cordic_arbiter_pkg::*;
#(
    parameter int  IO_WIDTH        = DEFAULT_IO_WIDTH,
    parameter int  NREQ            = 4,
    parameter int  MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
    parameter int  TIMEOUT         = 255,
    localparam int TW              = clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ*2*IO_WIDTH-1:0] S_TDATA,
    input  logic [NREQ-1:0]            S_TVALID,
    output logic [NREQ-1:0]            S_TREADY,
    output logic [2*IO_WIDTH-1:0]      C_TDATA,
    output logic [TW-1:0]              C_TUSER,
    output logic                       C_TVALID,
    input  logic [IO_WIDTH:0]          R_TDATA,
    input  logic [TW-1:0]              R_TUSER,
    input  logic                       R_TVALID,
    output logic [IO_WIDTH-1:0]        M_TDATA,
    output logic [NREQ-1:0]            M_TVALID,
    output logic                       overflowFlag,
    input  logic                       clearErrors,
    output logic                       spuriousError,
    output logic                       timeoutError
);

    localparam int OW  = clog2(MAX_OUTSTANDING + 1);
    localparam int WDW = clog2(TIMEOUT + 1);

    logic [OW-1:0]         outstanding_q [NREQ];
    logic [OW-1:0]         outstanding_d [NREQ];
    logic [TW-1:0]         last_grant_q, last_grant_d;
    logic [WDW-1:0]        wd_q, wd_d, wd_inc;
    logic [2*IO_WIDTH-1:0] c_tdata_q, c_tdata_d, c_sel;
    logic [TW-1:0]         c_tuser_q, c_tuser_d;
    logic                  c_tvalid_q, c_tvalid_d;
    logic [IO_WIDTH-1:0]   m_tdata_q, m_tdata_d;
    logic [NREQ-1:0]       m_tvalid_q, m_tvalid_d;
    logic                  ovf_q, ovf_d, spur_q, spur_d, tmo_q, tmo_d;

    logic [NREQ-1:0] eligible, grant, hs, ret;
    logic [TW-1:0]   grant_idx;
    logic            grant_valid, any_hs, result_ok, all_idle, fire;

    rr_select #(.NREQ(NREQ)) u_rr (
        .eligible_i    (eligible),
        .last_grant_i  (last_grant_q),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    assign S_TREADY = rst ? '0 : grant;
    assign hs       = S_TVALID & S_TREADY;
    assign any_hs   = grant_valid && !rst;

    always_comb begin
        eligible  = '0;
        ret       = '0;
        c_sel     = '0;
        all_idle  = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            eligible[k] = S_TVALID[k] && (outstanding_q[k] < OW'(MAX_OUTSTANDING));
            // A result only counts against a requester that actually has work in flight.
            ret[k]      = R_TVALID && (R_TUSER == TW'(k)) && (outstanding_q[k] != '0);
            if (grant[k]) c_sel = S_TDATA[k*2*IO_WIDTH +: 2*IO_WIDTH];
            if (outstanding_q[k] != '0) all_idle = 1'b0;
        end
        result_ok = |ret;

        wd_inc = wd_q + 1'b1;
        fire   = !R_TVALID && !all_idle && (wd_inc == WDW'(TIMEOUT));
        wd_d   = (R_TVALID || all_idle || fire) ? '0 : wd_inc;

        for (int k = 0; k < NREQ; k++) begin
            outstanding_d[k] = fire ? '0 : outstanding_q[k] + OW'(hs[k]) - OW'(ret[k]);
        end

        last_grant_d = any_hs ? grant_idx : last_grant_q;
        c_tvalid_d   = any_hs;
        c_tdata_d    = any_hs ? c_sel : c_tdata_q;
        c_tuser_d    = any_hs ? grant_idx : c_tuser_q;
        m_tvalid_d   = ret;
        m_tdata_d    = result_ok ? R_TDATA[IO_WIDTH-1:0] : m_tdata_q;
        ovf_d        = result_ok && R_TDATA[IO_WIDTH];
        spur_d       = (R_TVALID && !result_ok) || (spur_q && !clearErrors);
        tmo_d        = fire || (tmo_q && !clearErrors);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREQ; k++) outstanding_q[k] <= '0;
            last_grant_q <= TW'(NREQ - 1);
            wd_q         <= '0;
            c_tdata_q    <= '0;
            c_tuser_q    <= '0;
            c_tvalid_q   <= 1'b0;
            m_tdata_q    <= '0;
            m_tvalid_q   <= '0;
            ovf_q        <= 1'b0;
            spur_q       <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            for (int k = 0; k < NREQ; k++) outstanding_q[k] <= outstanding_d[k];
            last_grant_q <= last_grant_d;
            wd_q         <= wd_d;
            c_tdata_q    <= c_tdata_d;
            c_tuser_q    <= c_tuser_d;
            c_tvalid_q   <= c_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            m_tvalid_q   <= m_tvalid_d;
            ovf_q        <= ovf_d;
            spur_q       <= spur_d;
            tmo_q        <= tmo_d;
        end
    end

    assign C_TDATA       = c_tdata_q;
    assign C_TUSER       = c_tuser_q;
    assign C_TVALID      = c_tvalid_q;
    assign M_TDATA       = m_tdata_q;
    assign M_TVALID      = m_tvalid_q;
    assign overflowFlag  = ovf_q;
    assign spuriousError = spur_q;
    assign timeoutError  = tmo_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb/tb_cordic_arbiter.sv - scoreboard bench for cordic_arbiter with a 20-cycle |I|+|Q| CORDIC model
module tb_cordic_arbiter;

    localparam int IO = 26;
    localparam int NR = 4;
    localparam int TW = 2;
    localparam int DW = 2 * IO;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    typedef struct { logic [TW-1:0] tag; logic [DW-1:0] data; } c_exp_t;
    typedef struct { logic [NR-1:0] oh; logic [IO-1:0] mag; logic ovf; } m_exp_t;
    c_exp_t exp_c[$];
    m_exp_t exp_m[$];
    c_exp_t ce;
    m_exp_t me;

    logic [NR*DW-1:0] a_s_tdata, b_s_tdata;
    logic [NR-1:0]    a_s_tvalid, a_s_tready, b_s_tvalid, b_s_tready;
    logic [DW-1:0]    a_c_tdata, b_c_tdata;
    logic [TW-1:0]    a_c_tuser, b_c_tuser, a_r_tuser, b_r_tuser;
    logic             a_c_tvalid, b_c_tvalid, a_r_tvalid, b_r_tvalid;
    logic [IO:0]      a_r_tdata, b_r_tdata;
    logic [IO-1:0]    a_m_tdata, b_m_tdata;
    logic [NR-1:0]    a_m_tvalid, b_m_tvalid;
    logic             a_ovf, b_ovf, a_spur, b_spur, a_tmo, b_tmo;
    logic             a_clr;
    logic             b_clr = 1'b0;

    cordic_arbiter dut_a (
        .clk(clk), .rst(rst),
        .S_TDATA(a_s_tdata), .S_TVALID(a_s_tvalid), .S_TREADY(a_s_tready),
        .C_TDATA(a_c_tdata), .C_TUSER(a_c_tuser), .C_TVALID(a_c_tvalid),
        .R_TDATA(a_r_tdata), .R_TUSER(a_r_tuser), .R_TVALID(a_r_tvalid),
        .M_TDATA(a_m_tdata), .M_TVALID(a_m_tvalid), .overflowFlag(a_ovf),
        .clearErrors(a_clr), .spuriousError(a_spur), .timeoutError(a_tmo)
    );

    cordic_arbiter #(.MAX_OUTSTANDING(4)) dut_b (
        .clk(clk), .rst(rst),
        .S_TDATA(b_s_tdata), .S_TVALID(b_s_tvalid), .S_TREADY(b_s_tready),
        .C_TDATA(b_c_tdata), .C_TUSER(b_c_tuser), .C_TVALID(b_c_tvalid),
        .R_TDATA(b_r_tdata), .R_TUSER(b_r_tuser), .R_TVALID(b_r_tvalid),
        .M_TDATA(b_m_tdata), .M_TVALID(b_m_tvalid), .overflowFlag(b_ovf),
        .clearErrors(b_clr), .spuriousError(b_spur), .timeoutError(b_tmo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [IO:0] mag(input logic [DW-1:0] d);
        logic signed [IO-1:0] i, q;
        logic [IO:0] ai, aq;
        i  = d[IO-1:0];
        q  = d[DW-1:IO];
        ai = {1'b0, i[IO-1] ? -i : i};
        aq = {1'b0, q[IO-1] ? -q : q};
        return ai + aq;
    endfunction

    function automatic logic [DW-1:0] pk(input int i, input int q);
        logic [31:0] iv, qv;
        iv = i;
        qv = q;
        return {qv[IO-1:0], iv[IO-1:0]};
    endfunction

    // CORDIC model A: fixed 20-cycle pipe, one droppable entry, plus injected results
    logic [19:0]   a_pv = '0;
    logic [TW-1:0] a_pt [20];
    logic [IO:0]   a_pd [20];
    int unsigned   a_ccount = 0;
    int unsigned   drop_idx = 32'hFFFF_FFFF;
    logic          inj_v = 1'b0;
    logic [TW-1:0] inj_tag = '0;
    logic [IO:0]   inj_data = '0;

    always @(posedge clk) begin
        for (int i = 19; i > 0; i--) begin
            a_pt[i] <= a_pt[i-1];
            a_pd[i] <= a_pd[i-1];
        end
        a_pt[0] <= a_c_tuser;
        a_pd[0] <= mag(a_c_tdata);
        a_pv    <= {a_pv[18:0], a_c_tvalid && (a_ccount != drop_idx)};
        if (a_c_tvalid) a_ccount <= a_ccount + 1;
    end
    assign a_r_tvalid = a_pv[19] | inj_v;
    assign a_r_tuser  = inj_v ? inj_tag : a_pt[19];
    assign a_r_tdata  = inj_v ? inj_data : a_pd[19];

    logic [19:0]   b_pv = '0;
    logic [TW-1:0] b_pt [20];
    logic [IO:0]   b_pd [20];
    always @(posedge clk) begin
        for (int i = 19; i > 0; i--) begin
            b_pt[i] <= b_pt[i-1];
            b_pd[i] <= b_pd[i-1];
        end
        b_pt[0] <= b_c_tuser;
        b_pd[0] <= mag(b_c_tdata);
        b_pv    <= {b_pv[18:0], b_c_tvalid};
    end
    assign b_r_tvalid = b_pv[19];
    assign b_r_tuser  = b_pt[19];
    assign b_r_tdata  = b_pd[19];

    always @(negedge clk) begin
        if (a_c_tvalid) begin
            if (exp_c.size() == 0) begin
                checks++; fails++;
                $display("FAIL c_unexpected actual_tag=%0d expected=none", a_c_tuser);
            end else begin
                ce = exp_c.pop_front();
                check("c_tuser", 64'(a_c_tuser), 64'(ce.tag));
                check("c_tdata", 64'(a_c_tdata), 64'(ce.data));
            end
        end
        if (|a_m_tvalid) begin
            if (exp_m.size() == 0) begin
                checks++; fails++;
                $display("FAIL m_unexpected actual_tvalid=%0b expected=none", a_m_tvalid);
            end else begin
                me = exp_m.pop_front();
                check("m_tvalid", 64'(a_m_tvalid), 64'(me.oh));
                check("m_tdata", 64'(a_m_tdata), 64'(me.mag));
                check("m_ovf", 64'(a_ovf), 64'(me.ovf));
            end
        end else if (a_ovf) begin
            checks++; fails++;
            $display("FAIL ovf_stray actual=1 expected=0");
        end
        if (b_c_tvalid) check("v3_c_tuser", 64'(b_c_tuser), 64'(1));
        if (|b_m_tvalid) begin
            check("v3_m_tvalid", 64'(b_m_tvalid), 64'(4'b0010));
            check("v3_m_tdata", 64'(b_m_tdata), 64'(16));
            check("v3_m_ovf", 64'(b_ovf), 64'(0));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_c(input int tag, input logic [DW-1:0] d);
        c_exp_t e;
        e.tag  = tag[TW-1:0];
        e.data = d;
        exp_c.push_back(e);
    endtask

    task automatic push_m(input logic [NR-1:0] oh, input int m, input logic o);
        m_exp_t e;
        e.oh  = oh;
        e.mag = m[IO-1:0];
        e.ovf = o;
        exp_m.push_back(e);
    endtask

    int            v1_seq [5] = '{0, 1, 2, 3, 0};
    int            v1_mag [4] = '{7, 150, 0, 1000};
    logic          v1_ovf [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [DW-1:0] v1_dat [4];
    logic [NR-1:0] exp_rdy;

    initial begin
        rst        = 1'b1;
        a_clr      = 1'b0;
        a_s_tdata  = '0;
        b_s_tdata  = '0;
        b_s_tvalid = '0;
        v1_dat[0]  = pk(3, -4);
        v1_dat[1]  = pk(-100, 50);
        v1_dat[2]  = pk(-33554432, -33554432);
        v1_dat[3]  = pk(1000, 0);
        for (int k = 0; k < NR; k++) a_s_tdata[k*DW +: DW] = v1_dat[k];
        a_s_tvalid = 4'hF;
        step();
        step();

        check("rst_s_tready", 64'(a_s_tready), 64'(0));
        check("rst_c_tvalid", 64'(a_c_tvalid), 64'(0));
        check("rst_c_tdata", 64'(a_c_tdata), 64'(0));
        check("rst_c_tuser", 64'(a_c_tuser), 64'(0));
        check("rst_m_tvalid", 64'(a_m_tvalid), 64'(0));
        check("rst_m_tdata", 64'(a_m_tdata), 64'(0));
        check("rst_ovf", 64'(a_ovf), 64'(0));
        check("rst_spur", 64'(a_spur), 64'(0));
        check("rst_tmo", 64'(a_tmo), 64'(0));

        // V1: reset priority with all requesters valid
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            #1;
            check("v1_ready", 64'(a_s_tready), 64'(1 << v1_seq[n]));
            push_c(v1_seq[n], v1_dat[v1_seq[n]]);
            push_m(NR'(1 << v1_seq[n]), v1_mag[v1_seq[n]], v1_ovf[v1_seq[n]]);
            step();
        end
        a_s_tvalid = '0;
        repeat (25) step();

        // V2: single requester streaming, results 22 cycles after first handshake
        a_s_tvalid = 4'b0100;
        for (int n = 0; n < 10; n++) begin
            a_s_tdata[2*DW +: DW] = pk(16 * n + 5, -3);
            #1;
            check("v2_ready", 64'(a_s_tready), 64'(4'b0100));
            push_c(2, pk(16 * n + 5, -3));
            push_m(4'b0100, 16 * n + 8, 1'b0);
            step();
        end
        a_s_tvalid = '0;
        repeat (11) step();
        check("v2_m_before", 64'(a_m_tvalid), 64'(0));
        for (int j = 0; j < 10; j++) begin
            step();
            check("v2_m_tvalid", 64'(a_m_tvalid), 64'(4'b0100));
        end
        step();
        check("v2_m_after", 64'(a_m_tvalid), 64'(0));

        // V4: spurious result and error clearing
        check("v4_spur_pre", 64'(a_spur), 64'(0));
        inj_tag  = 2'd3;
        inj_data = 27'd5;
        inj_v    = 1'b1;
        step();
        inj_v = 1'b0;
        check("v4_m_tvalid", 64'(a_m_tvalid), 64'(0));
        check("v4_spur", 64'(a_spur), 64'(1));
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        check("v4_spur_clr", 64'(a_spur), 64'(0));
        inj_v = 1'b1;
        a_clr = 1'b1;
        step();
        inj_v = 1'b0;
        a_clr = 1'b0;
        check("v4_spur_hold", 64'(a_spur), 64'(1));
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        check("v4_spur_clr2", 64'(a_spur), 64'(0));

        // V5: requester 1's result is lost, watchdog fires 255 cycles after the last result
        drop_idx = a_ccount + 1;
        a_s_tdata[0*DW +: DW] = pk(-20, 22);
        a_s_tdata[1*DW +: DW] = pk(9, 9);
        a_s_tvalid = 4'b0001;
        #1;
        check("v5_ready0", 64'(a_s_tready), 64'(4'b0001));
        push_c(0, pk(-20, 22));
        push_m(4'b0001, 42, 1'b0);
        step();
        a_s_tvalid = 4'b0010;
        #1;
        check("v5_ready1", 64'(a_s_tready), 64'(4'b0010));
        push_c(1, pk(9, 9));
        step();
        a_s_tvalid = '0;
        repeat (274) step();
        check("v5_tmo_early", 64'(a_tmo), 64'(0));
        step();
        check("v5_tmo", 64'(a_tmo), 64'(1));
        drop_idx = 32'hFFFF_FFFF;
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        check("v5_tmo_clr", 64'(a_tmo), 64'(0));
        inj_tag  = 2'd1;
        inj_data = 27'd18;
        inj_v    = 1'b1;
        step();
        inj_v = 1'b0;
        check("v5_zeroed_m", 64'(a_m_tvalid), 64'(0));
        check("v5_zeroed_spur", 64'(a_spur), 64'(1));
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        a_s_tdata[3*DW +: DW] = pk(0, -77);
        a_s_tvalid = 4'b1000;
        #1;
        check("v5_regrant", 64'(a_s_tready), 64'(4'b1000));
        push_c(3, pk(0, -77));
        push_m(4'b1000, 77, 1'b0);
        step();
        a_s_tvalid = '0;
        repeat (25) step();

        // V6: mid-stream reset
        for (int k = 0; k < NR; k++) a_s_tdata[k*DW +: DW] = v1_dat[k];
        a_s_tvalid = 4'hF;
        for (int n = 0; n < 3; n++) begin
            #1;
            check("v6_ready", 64'(a_s_tready), 64'(1 << n));
            push_c(n, v1_dat[n]);
            step();
        end
        rst = 1'b1;
        #1;
        check("v6_ready_rst", 64'(a_s_tready), 64'(0));
        step();
        check("v6_c_tvalid", 64'(a_c_tvalid), 64'(0));
        check("v6_c_tdata", 64'(a_c_tdata), 64'(0));
        check("v6_c_tuser", 64'(a_c_tuser), 64'(0));
        check("v6_m_tvalid", 64'(a_m_tvalid), 64'(0));
        check("v6_m_tdata", 64'(a_m_tdata), 64'(0));
        check("v6_ovf", 64'(a_ovf), 64'(0));
        check("v6_spur", 64'(a_spur), 64'(0));
        check("v6_tmo", 64'(a_tmo), 64'(0));
        rst = 1'b0;
        a_s_tvalid = '0;
        repeat (26) step();
        check("v6_late_spur", 64'(a_spur), 64'(1));
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        a_s_tvalid = 4'hF;
        #1;
        check("v6_restart", 64'(a_s_tready), 64'(4'b0001));
        push_c(0, v1_dat[0]);
        push_m(4'b0001, 7, 1'b0);
        step();
        a_s_tvalid = '0;
        repeat (25) step();

        // V3: in-flight limit of 4 on the second instance
        b_s_tdata[1*DW +: DW] = pk(7, -9);
        b_s_tvalid = 4'b0010;
        for (int c = 0; c < 30; c++) begin
            #1;
            exp_rdy = ((c < 4) || (c >= 22 && c < 26)) ? 4'b0010 : 4'b0000;
            check("v3_ready", 64'(b_s_tready), 64'(exp_rdy));
            step();
        end
        b_s_tvalid = '0;
        repeat (25) step();

        check("end_exp_c_empty", 64'(exp_c.size()), 64'(0));
        check("end_exp_m_empty", 64'(exp_m.size()), 64'(0));
        check("end_b_spur", 64'(b_spur), 64'(0));
        check("end_b_tmo", 64'(b_tmo), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
